// File: rtl/blue_die_sprite_fetch.sv
// Blue-die sprite fetch: maps the VGA draw coordinate to a die sprite ROM
// address, aligns the returned palette index with an in-box flag, and runs
// the die-roll animation that selects the displayed face.
//
// state   | meaning
// IDLE    | face stable, waiting for roll_start
// ROLLING | face advances on each frame_tick until the last tick of the roll
// SETTLED | one-cycle done pulse after landing on the target face
module blue_die_sprite_fetch #(
  parameter int         DIE_W           = 32,
  parameter int         DIE_H           = 32,
  parameter int         ROLL_FRAMES     = 12,
  parameter logic [3:0] TRANSPARENT_IDX = 4'd0,
  parameter int         ADDR_W          = 13
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              roll_start,
  input  logic [2:0]        roll_value,
  input  logic [9:0]        die_x,
  input  logic [9:0]        die_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        palette_index,
  output logic              pixel_on,
  output logic [2:0]        face,
  output logic              busy,
  output logic              done
);

  localparam int XW = $clog2(DIE_W);
  localparam int YW = $clog2(DIE_H);
  localparam int CW = $clog2(ROLL_FRAMES);
  localparam logic [10:0]   DIE_W11  = 11'(DIE_W);
  localparam logic [10:0]   DIE_H11  = 11'(DIE_H);
  localparam logic [CW-1:0] CNT_LAST = CW'(ROLL_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SETTLED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    face_nxt;
  logic [2:0]    target, target_nxt;
  logic [CW-1:0] roll_cnt, roll_cnt_nxt;

  logic              in_box, in_box_d1, in_box_d2;
  logic [10:0]       x_end, y_end;
  logic [XW-1:0]     dx;
  logic [YW-1:0]     dy;
  logic [2:0]        face_m1;
  logic [ADDR_W-1:0] row, addr_nxt;

  // Stage 1 address math; 11-bit compares so a die near column/row 1023 does not wrap.
  always_comb begin
    x_end    = {1'b0, die_x} + DIE_W11;
    y_end    = {1'b0, die_y} + DIE_H11;
    in_box   = ({1'b0, DrawX} >= {1'b0, die_x}) && ({1'b0, DrawX} < x_end) &&
               ({1'b0, DrawY} >= {1'b0, die_y}) && ({1'b0, DrawY} < y_end);
    // Power-of-2 sprite: the low bits of the difference are the offset mod size.
    dx       = DrawX[XW-1:0] - die_x[XW-1:0];
    dy       = DrawY[YW-1:0] - die_y[YW-1:0];
    face_m1  = face - 3'd1;
    row      = ADDR_W'(face_m1) * ADDR_W'(DIE_H) + ADDR_W'(dy);
    addr_nxt = row * ADDR_W'(DIE_W) + ADDR_W'(dx);
  end

  // Pixel pipeline registers: ROM address plus in-box flag delayed to match ROM latency.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
    end else begin
      rom_addr  <= addr_nxt;
      in_box_d1 <= in_box;
      in_box_d2 <= in_box_d1;
    end
  end

  // Stage 2 output masking: outside the box the index is forced to 0.
  always_comb begin
    palette_index = in_box_d2 ? rom_data : 4'd0;
    pixel_on      = in_box_d2 && (rom_data != TRANSPARENT_IDX);
  end

  // Roll FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      face     <= 3'd1;
      target   <= 3'd1;
      roll_cnt <= '0;
    end else begin
      state    <= state_nxt;
      face     <= face_nxt;
      target   <= target_nxt;
      roll_cnt <= roll_cnt_nxt;
    end
  end

  // Roll FSM next-state and outputs; face only moves on frame ticks.
  always_comb begin
    state_nxt    = state;
    face_nxt     = face;
    target_nxt   = target;
    roll_cnt_nxt = roll_cnt;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (roll_start) begin
          // Out-of-range roll values clamp to the nearest legal face.
          if (roll_value == 3'd0)      target_nxt = 3'd1;
          else if (roll_value == 3'd7) target_nxt = 3'd6;
          else                         target_nxt = roll_value;
          roll_cnt_nxt = '0;
          state_nxt    = ROLLING;
        end
      end
      ROLLING: begin
        busy = 1'b1;
        if (frame_tick) begin
          if (roll_cnt == CNT_LAST) begin
            face_nxt  = target;
            state_nxt = SETTLED;
          end else begin
            face_nxt     = (face == 3'd6) ? 3'd1 : face + 3'd1;
            roll_cnt_nxt = roll_cnt + 1'b1;
          end
        end
      end
      SETTLED: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_blue_die_sprite_fetch.sv
// Directed bench for blue_die_sprite_fetch with a behavioural synchronous ROM.
module tb_blue_die_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick, roll_start;
  logic [2:0]  roll_value;
  logic [9:0]  die_x, die_y, DrawX, DrawY;
  logic [12:0] rom_addr;
  logic [3:0]  rom_data = 4'd0;
  logic [3:0]  palette_index;
  logic        pixel_on;
  logic [2:0]  face;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [2:0] m_face = 3'd1;

  blue_die_sprite_fetch dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .roll_start(roll_start),
    .roll_value(roll_value), .die_x(die_x), .die_y(die_y), .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr), .rom_data(rom_data), .palette_index(palette_index),
    .pixel_on(pixel_on), .face(face), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // ROM contents: low address nibble plus 5 (address 0 holds 5, offset 11 is transparent).
  function automatic logic [3:0] rom_fn(logic [12:0] a);
    return a[3:0] + 4'd5;
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  always @(negedge Clk) if (done === 1'b1) done_cnt++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    roll_start = 1'b0;
  endtask

  task automatic do_roll(input logic [2:0] val, input logic [2:0] exp_final,
                         input bit with_tick, input bit inject);
    int d0;
    roll_start = 1'b1;
    roll_value = val;
    frame_tick = with_tick;
    step();
    roll_start = 1'b0;
    frame_tick = 1'b0;
    chk("roll_start_face", 32'(face), 32'(m_face));
    chk("roll_start_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    for (int i = 1; i <= 11; i++) begin
      if (inject && i == 3) begin
        roll_start = 1'b1;
        roll_value = 3'd2;
      end
      tick();
      m_face = (m_face == 3'd6) ? 3'd1 : m_face + 3'd1;
      chk("roll_tick_face", 32'(face), 32'(m_face));
      chk("roll_tick_busy", 32'(busy), 32'd1);
      chk("roll_tick_done", 32'(done), 32'd0);
      step();
    end
    tick();
    m_face = exp_final;
    chk("settle_face", 32'(face), 32'(exp_final));
    chk("settle_busy", 32'(busy), 32'd0);
    chk("settle_done", 32'(done), 32'd1);
    roll_start = 1'b1;
    roll_value = 3'd5;
    step();
    roll_start = 1'b0;
    chk("after_settle_done", 32'(done), 32'd0);
    chk("settled_start_ignored", 32'(busy), 32'd0);
    chk("done_pulse_count", 32'(done_cnt - d0), 32'd1);
    step();
    chk("still_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [9:0]  dxi, dyi, px, py;
    logic [12:0] addr;
    logic [3:0]  idx;
    logic        on;
  } pix_vec_t;

  pix_vec_t vecs[10];

  initial begin
    int d0;
    vecs[0] = '{10'd100,  10'd50,   10'd100,  10'd50,   13'd0,    4'd5,  1'b1};
    vecs[1] = '{10'd100,  10'd50,   10'd105,  10'd57,   13'd229,  4'd10, 1'b1};
    vecs[2] = '{10'd100,  10'd50,   10'd131,  10'd81,   13'd1023, 4'd4,  1'b1};
    vecs[3] = '{10'd100,  10'd50,   10'd132,  10'd50,   13'd0,    4'd0,  1'b0};
    vecs[4] = '{10'd100,  10'd50,   10'd100,  10'd49,   13'd992,  4'd0,  1'b0};
    vecs[5] = '{10'd100,  10'd50,   10'd99,   10'd50,   13'd31,   4'd0,  1'b0};
    vecs[6] = '{10'd100,  10'd50,   10'd111,  10'd50,   13'd11,   4'd0,  1'b0};
    vecs[7] = '{10'd100,  10'd50,   10'd100,  10'd82,   13'd0,    4'd0,  1'b0};
    vecs[8] = '{10'd1000, 10'd1000, 10'd1023, 10'd1010, 13'd343,  4'd12, 1'b1};
    vecs[9] = '{10'd1000, 10'd1000, 10'd5,    10'd1010, 13'd349,  4'd0,  1'b0};

    Reset = 1'b1;
    frame_tick = 1'b0;
    roll_start = 1'b0;
    roll_value = 3'd0;
    die_x = 10'd100;
    die_y = 10'd50;
    DrawX = 10'd0;
    DrawY = 10'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_face", 32'(face), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_pixel_on", 32'(pixel_on), 32'd0);
    chk("reset_palette", 32'(palette_index), 32'd0);
    Reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      die_x = vecs[i].dxi;
      die_y = vecs[i].dyi;
      DrawX = vecs[i].px;
      DrawY = vecs[i].py;
      step();
      chk($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      step();
      chk($sformatf("vec%0d_palette", i), 32'(palette_index), 32'(vecs[i].idx));
      chk($sformatf("vec%0d_pixel_on", i), 32'(pixel_on), 32'(vecs[i].on));
    end

    do_roll(3'd4, 3'd4, 1'b0, 1'b0);
    do_roll(3'd3, 3'd3, 1'b0, 1'b1);

    die_x = 10'd100;
    die_y = 10'd50;
    DrawX = 10'd105;
    DrawY = 10'd57;
    step();
    chk("face3_rom_addr", 32'(rom_addr), 32'd2277);
    step();
    chk("face3_palette", 32'(palette_index), 32'd10);
    chk("face3_pixel_on", 32'(pixel_on), 32'd1);

    do_roll(3'd0, 3'd1, 1'b1, 1'b0);
    do_roll(3'd7, 3'd6, 1'b0, 1'b0);

    // Reset in the middle of a roll, with the beam inside the die.
    DrawX = 10'd100;
    DrawY = 10'd50;
    roll_start = 1'b1;
    roll_value = 3'd3;
    step();
    roll_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      step();
    end
    step();
    chk("pre_reset_pixel_on", 32'(pixel_on), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_reset_face", 32'(face), 32'd1);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_pixel_on", 32'(pixel_on), 32'd0);
    chk("async_reset_rom_addr", 32'(rom_addr), 32'd0);
    d0 = done_cnt;
    #3;
    Reset = 1'b0;
    m_face = 3'd1;
    for (int i = 0; i < 14; i++) begin
      tick();
      step();
    end
    chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
    chk("post_reset_face", 32'(face), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
